// File: rtl/combi_bist_driver.sv
// BIST stimulus/response stage for the 16-input combi tree: applies counter or
// LFSR vectors, samples the tree output after a settle window, builds a MISR.
module combi_bist_driver #(
  parameter int unsigned       WIDTH  = 16,
  parameter int unsigned       SETTLE = 1,
  parameter logic [WIDTH-1:0]  POLY   = 16'hB400,
  parameter int unsigned       CNT_W  = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] num_vec,
  output logic [WIDTH-1:0] vec_out,
  input  logic             dut_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
    return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      num_q     <= '0;
      vec_idx_q <= '0;
      ones_q    <= '0;
      sig_q     <= '0;
      vec_q     <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      vec_idx_q <= vec_idx_d;
      ones_q    <= ones_d;
      sig_q     <= sig_d;
      vec_q     <= vec_d;
      settle_q  <= settle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_d     = num_q;
    vec_idx_d = vec_idx_q;
    ones_d    = ones_q;
    sig_d     = sig_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mode_d    = mode;
          num_d     = num_vec;
          ones_d    = '0;
          sig_d     = '0;
          vec_idx_d = '0;
          if (num_vec == '0) begin
            state_d = DONE;
          end else begin
            // An all-zero LFSR seed would lock up, so it is replaced by 1.
            vec_d    = (mode && seed == '0) ? WIDTH'(1) : seed;
            settle_d = 4'd1;
            state_d  = APPLY;
          end
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_L) state_d = SAMPLE;
        else                      settle_d = settle_q + 4'd1;
      end
      SAMPLE: begin
        ones_d    = ones_q + CNT_W'(dut_in);
        sig_d     = step(sig_q) ^ {{(WIDTH-1){1'b0}}, dut_in};
        vec_idx_d = vec_idx_q + CNT_W'(1);
        // The final vector stays on the bus instead of advancing past it.
        if (vec_idx_q + CNT_W'(1) == num_q) begin
          state_d = DONE;
        end else begin
          vec_d    = mode_q ? step(vec_q) : vec_q + WIDTH'(1);
          settle_d = 4'd1;
          state_d  = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec_out   = vec_q;
  assign busy      = (state_q == APPLY) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign ones_cnt  = ones_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_combi_bist_driver.sv
// Directed bench for combi_bist_driver with SETTLE=1; dut_in is driven by the
// bench in place of the combi tree.
module tb_combi_bist_driver;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [15:0] seed;
  logic [16:0] num_vec;
  logic [15:0] vec_out;
  logic        dut_in;
  logic        busy;
  logic        done;
  logic [16:0] ones_cnt;
  logic [15:0] signature;

  int checks   = 0;
  int failures = 0;

  combi_bist_driver #(
    .WIDTH (16),
    .SETTLE(1),
    .POLY  (16'hB400),
    .CNT_W (17)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .seed     (seed),
    .num_vec  (num_vec),
    .vec_out  (vec_out),
    .dut_in   (dut_in),
    .busy     (busy),
    .done     (done),
    .ones_cnt (ones_cnt),
    .signature(signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int cyc;
  bit saw_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; num_vec = '0; dut_in = 1'b0;
    tick(); tick();
    check("rst_vec", 32'(vec_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ones", 32'(ones_cnt), 32'h0);
    check("rst_sig", 32'(signature), 32'h0);
    rst_n = 1'b1;
    tick();

    // num_vec = 0: done in cycle 1, vec_out untouched
    start = 1'b1; mode = 1'b0; seed = 16'h1234; num_vec = 17'd0;
    tick(); start = 1'b0;
    check("n0_done", 32'(done), 32'h1);
    check("n0_busy", 32'(busy), 32'h0);
    check("n0_vec", 32'(vec_out), 32'h0);
    check("n0_sig", 32'(signature), 32'h0);
    tick();
    check("n0_done_clr", 32'(done), 32'h0);

    // mode 1, seed 0 -> 0001, B400, 5A00, each for 2 cycles, done at cycle 7
    start = 1'b1; mode = 1'b1; seed = 16'h0000; num_vec = 17'd3;
    tick(); start = 1'b0;
    check("l_c1_vec", 32'(vec_out), 32'h0001);
    check("l_c1_busy", 32'(busy), 32'h1);
    tick(); check("l_c2_vec", 32'(vec_out), 32'h0001);
    tick(); check("l_c3_vec", 32'(vec_out), 32'hB400);
    tick(); check("l_c4_vec", 32'(vec_out), 32'hB400);
    check("l_c4_done", 32'(done), 32'h0);
    tick(); check("l_c5_vec", 32'(vec_out), 32'h5A00);
    tick(); check("l_c6_vec", 32'(vec_out), 32'h5A00);
    tick();
    check("l_c7_done", 32'(done), 32'h1);
    check("l_c7_busy", 32'(busy), 32'h0);
    check("l_c7_vec", 32'(vec_out), 32'h5A00);
    check("l_c7_ones", 32'(ones_cnt), 32'h0);
    check("l_c7_sig", 32'(signature), 32'h0);

    // restart straight out of DONE: mode 0, seed 0, 3 vectors, dut_in=0 only in
    // cycle 4 (second SAMPLE); samples 1,0,1 -> sig 0001, B400, 5A01
    start = 1'b1; mode = 1'b0; seed = 16'h0000; num_vec = 17'd3;
    tick(); start = 1'b0;
    check("c_c1_vec", 32'(vec_out), 32'h0000);
    check("c_c1_ones", 32'(ones_cnt), 32'h0);
    dut_in = 1'b1;
    tick(); tick();
    check("c_c3_vec", 32'(vec_out), 32'h0001);
    check("c_c3_ones", 32'(ones_cnt), 32'h1);
    check("c_c3_sig", 32'(signature), 32'h0001);
    tick(); dut_in = 1'b0;
    tick(); dut_in = 1'b1;
    check("c_c5_vec", 32'(vec_out), 32'h0002);
    check("c_c5_sig", 32'(signature), 32'hB400);
    tick(); tick();
    check("c_c7_done", 32'(done), 32'h1);
    check("c_c7_ones", 32'(ones_cnt), 32'h2);
    check("c_c7_sig", 32'(signature), 32'h5A01);
    check("c_c7_vec", 32'(vec_out), 32'h0002);
    dut_in = 1'b0;
    tick();
    check("c_hold_done", 32'(done), 32'h0);
    check("c_hold_ones", 32'(ones_cnt), 32'h2);
    check("c_hold_sig", 32'(signature), 32'h5A01);
    check("c_hold_vec", 32'(vec_out), 32'h0002);

    // mode 0 wrap: FFFE, FFFF, 0000
    start = 1'b1; mode = 1'b0; seed = 16'hFFFE; num_vec = 17'd3;
    tick(); start = 1'b0;
    tick(); tick();
    check("w_c3_vec", 32'(vec_out), 32'hFFFF);
    tick(); tick(); tick(); tick();
    check("w_c7_done", 32'(done), 32'h1);
    check("w_c7_vec", 32'(vec_out), 32'h0000);
    tick();

    // 100-vector run, start pulsed at cycle 20 with different arguments
    start = 1'b1; mode = 1'b0; seed = 16'h0000; num_vec = 17'd100;
    tick(); start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      if (cyc == 20) begin
        start = 1'b1; mode = 1'b1; seed = 16'hAAAA; num_vec = 17'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("b_done_seen", 32'(done), 32'h1);
    check("b_done_cycle", 32'(cyc), 32'd201);
    check("b_vec", 32'(vec_out), 32'h0063);
    tick();

    // rerun with dut_in=1, then drop rst_n asynchronously in cycle 50
    start = 1'b1; mode = 1'b0; seed = 16'h0000; num_vec = 17'd100; dut_in = 1'b1;
    tick(); start = 1'b0;
    repeat (49) tick();
    check("r_pre_busy", 32'(busy), 32'h1);
    check("r_pre_ones", 32'(ones_cnt), 32'd24);
    #1 rst_n = 1'b0;
    #1;
    check("r_async_vec", 32'(vec_out), 32'h0);
    check("r_async_busy", 32'(busy), 32'h0);
    check("r_async_ones", 32'(ones_cnt), 32'h0);
    check("r_async_sig", 32'(signature), 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("r_no_done", 32'(saw_done), 32'h0);
    check("r_idle_busy", 32'(busy), 32'h0);
    dut_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
